// File: rtl/proj_errmon_pkg.sv
// Shared types and defaults for the lane error monitor: FSM encoding and
// default counter widths.
package proj_errmon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int unsigned DEF_EW = 8;
  localparam int unsigned DEF_SW = 16;
  localparam int unsigned DEF_TW = 32;

endpackage

// File: rtl/proj_errmon_errdelta.sv
// Tracks the previous lane error count and returns the wrap-aware number of
// new errors seen since the last clock.
module proj_errdelta #(
  parameter int unsigned EW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [EW-1:0] errcntr_i,
  output logic [EW-1:0] delta_o
);

  logic [EW-1:0] prev_q;

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples its inputs from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) prev_q <= '0;
    else      prev_q <= errcntr_i;
  end

  // Modular subtraction: a counter wrap such as 0xFF -> 0x00 still yields 1.
  assign delta_o = errcntr_i - prev_q;

endmodule

// File: rtl/proj_errmon.sv
// Pass/fail monitor for one lane: runs a WIN-cycle test window on start and
// reports a latched verdict, saturating error total and first-error cycle.
module proj_errmon
  import proj_errmon_pkg::*;
#(
  parameter int unsigned EW  = DEF_EW,
  parameter int unsigned SW  = DEF_SW,
  parameter int unsigned TW  = DEF_TW,
  parameter int unsigned WIN = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [EW-1:0] errcntr,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [SW-1:0] errtotal,
  output logic [TW-1:0] firsterr
);

  localparam int unsigned   AW   = ((SW > EW) ? SW : EW) + 1;
  localparam logic [SW-1:0] SAT  = '1;
  localparam logic [TW-1:0] LAST = TW'(WIN - 1);

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [SW-1:0] errtotal_q, errtotal_d;
  logic [TW-1:0] firsterr_q, firsterr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic [EW-1:0] delta;
  logic [AW-1:0] sum;

  proj_errdelta #(.EW(EW)) u_delta (
    .clk       (clk),
    .rst       (rst),
    .errcntr_i (errcntr),
    .delta_o   (delta)
  );

  // Wide enough that one delta on top of a near-full total cannot overflow.
  assign sum = AW'(errtotal_q) + AW'(delta);

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement leaves a value unassigned and infers a latch.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    errtotal_d = errtotal_q;
    firsterr_d = firsterr_q;
    pass_d     = pass_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_ARM;
      ST_ARM: begin
        // Baseline cycle: this cycle's delta is deliberately dropped.
        timer_d    = '0;
        errtotal_d = '0;
        firsterr_d = '1;
        pass_d     = 1'b0;
        state_d    = ST_RUN;
      end
      ST_RUN: begin
        timer_d    = timer_q + TW'(1);
        errtotal_d = (sum > AW'(SAT)) ? SAT : sum[SW-1:0];
        if ((delta != '0) && (firsterr_q == '1)) firsterr_d = timer_q;
        if (timer_q == LAST) begin
          state_d = ST_DONE;
          pass_d  = (errtotal_d == '0);
        end
      end
      ST_DONE: if (start) state_d = ST_ARM;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_ARM) || (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      errtotal_q <= '0;
      firsterr_q <= '1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      errtotal_q <= errtotal_d;
      firsterr_q <= firsterr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign errtotal = errtotal_q;
  assign firsterr = firsterr_q;

endmodule
